// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: register numbers, ALU ops and the
// control bundle whose all-zero-effect value forms a pipeline bubble.
package id_ex_stage_pkg;

    localparam int unsigned CORE_XLEN = 32;

    typedef logic [4:0] reg_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic    wen;
        logic    mem_read;
        logic    mem_write;
        alu_op_t alu_op;
        logic    alu_src;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_BUBBLE_CTRL = '{
        wen:       1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_op:    ALU_ADD,
        alu_src:   1'b0
    };

    function automatic logic is_x0(reg_t r);
        return r == 5'd0;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side operand/control bundle and its registered EX-side copy.
// master drives ID and observes EX; slave is the pipeline register itself.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
);
    logic            i_ID_valid;
    logic [XLEN-1:0] i_ID_pc;
    reg_t            i_ID_rnum1;
    reg_t            i_ID_rnum2;
    logic            i_ID_uses_rs1;
    logic            i_ID_uses_rs2;
    reg_t            i_ID_wnum;
    logic            i_ID_wen;
    logic            i_ID_mem_read;
    logic            i_ID_mem_write;
    logic [XLEN-1:0] i_ID_rdata1;
    logic [XLEN-1:0] i_ID_rdata2;
    logic [XLEN-1:0] i_ID_imm;
    alu_op_t         i_ID_alu_op;
    logic            i_ID_alu_src;

    logic            o_EX_valid;
    logic [XLEN-1:0] o_EX_pc;
    reg_t            o_EX_rnum1;
    reg_t            o_EX_rnum2;
    logic            o_EX_uses_rs1;
    logic            o_EX_uses_rs2;
    reg_t            o_EX_wnum;
    logic            o_EX_wen;
    logic            o_EX_mem_read;
    logic            o_EX_mem_write;
    logic [XLEN-1:0] o_EX_rdata1;
    logic [XLEN-1:0] o_EX_rdata2;
    logic [XLEN-1:0] o_EX_imm;
    alu_op_t         o_EX_alu_op;
    logic            o_EX_alu_src;

    modport master (
        output i_ID_valid, i_ID_pc, i_ID_rnum1, i_ID_rnum2, i_ID_uses_rs1, i_ID_uses_rs2,
               i_ID_wnum, i_ID_wen, i_ID_mem_read, i_ID_mem_write, i_ID_rdata1, i_ID_rdata2,
               i_ID_imm, i_ID_alu_op, i_ID_alu_src,
        input  o_EX_valid, o_EX_pc, o_EX_rnum1, o_EX_rnum2, o_EX_uses_rs1, o_EX_uses_rs2,
               o_EX_wnum, o_EX_wen, o_EX_mem_read, o_EX_mem_write, o_EX_rdata1, o_EX_rdata2,
               o_EX_imm, o_EX_alu_op, o_EX_alu_src
    );

    modport slave (
        input  i_ID_valid, i_ID_pc, i_ID_rnum1, i_ID_rnum2, i_ID_uses_rs1, i_ID_uses_rs2,
               i_ID_wnum, i_ID_wen, i_ID_mem_read, i_ID_mem_write, i_ID_rdata1, i_ID_rdata2,
               i_ID_imm, i_ID_alu_op, i_ID_alu_src,
        output o_EX_valid, o_EX_pc, o_EX_rnum1, o_EX_rnum2, o_EX_uses_rs1, o_EX_uses_rs2,
               o_EX_wnum, o_EX_wen, o_EX_mem_read, o_EX_mem_write, o_EX_rdata1, o_EX_rdata2,
               o_EX_imm, o_EX_alu_op, o_EX_alu_src
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard term: a load in EX whose non-x0 destination is read by the ID instruction.
module id_ex_stage_load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic i_ID_valid,
    input  reg_t i_ID_rnum1,
    input  reg_t i_ID_rnum2,
    input  logic i_ID_uses_rs1,
    input  logic i_ID_uses_rs2,
    input  logic i_EX_valid,
    input  logic i_EX_mem_read,
    input  reg_t i_EX_wnum,
    output logic o_lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_ID_uses_rs1 && (i_EX_wnum == i_ID_rnum1);
    assign w_rs2_hit = i_ID_uses_rs2 && (i_EX_wnum == i_ID_rnum2);

    assign o_lu = i_ID_valid && i_EX_valid && i_EX_mem_read && !is_x0(i_EX_wnum)
                  && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream stall.
// Optional hazard counters are built when ID_EX_HAZARD_STATS_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    id_ex_stage_if.slave       id_ex,
    input  logic               i_flush,
    input  logic               i_stall,
`ifdef ID_EX_HAZARD_STATS_EN
    output logic [31:0]        o_lu_stall_cnt,
    output logic [31:0]        o_flush_cnt,
`endif
    output logic               o_ID_stall
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    reg_t            r_rnum1;
    reg_t            r_rnum2;
    logic            r_uses_rs1;
    logic            r_uses_rs2;
    reg_t            r_wnum;
    logic [XLEN-1:0] r_rdata1;
    logic [XLEN-1:0] r_rdata2;
    logic [XLEN-1:0] r_imm;
    id_ex_ctrl_t     r_ctrl;
    logic            r_flush_pending;

    logic            w_lu;
    logic            w_kill;
    logic            w_bubble;
    id_ex_ctrl_t     w_id_ctrl;

    id_ex_stage_load_use_detect u_load_use_detect (
        .i_ID_valid    (id_ex.i_ID_valid),
        .i_ID_rnum1    (id_ex.i_ID_rnum1),
        .i_ID_rnum2    (id_ex.i_ID_rnum2),
        .i_ID_uses_rs1 (id_ex.i_ID_uses_rs1),
        .i_ID_uses_rs2 (id_ex.i_ID_uses_rs2),
        .i_EX_valid    (r_valid),
        .i_EX_mem_read (r_ctrl.mem_read),
        .i_EX_wnum     (r_wnum),
        .o_lu          (w_lu)
    );

    // A flush seen while frozen is remembered and applied on the first free edge.
    assign w_kill   = i_flush || r_flush_pending;
    assign w_bubble = w_kill || w_lu;

    assign w_id_ctrl = '{
        wen:       id_ex.i_ID_wen,
        mem_read:  id_ex.i_ID_mem_read,
        mem_write: id_ex.i_ID_mem_write,
        alu_op:    id_ex.i_ID_alu_op,
        alu_src:   id_ex.i_ID_alu_src
    };

    assign o_ID_stall = i_stall || (w_lu && !w_kill);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid         <= 1'b0;
            r_pc            <= RESET_PC;
            r_rnum1         <= '0;
            r_rnum2         <= '0;
            r_uses_rs1      <= 1'b0;
            r_uses_rs2      <= 1'b0;
            r_wnum          <= '0;
            r_rdata1        <= '0;
            r_rdata2        <= '0;
            r_imm           <= '0;
            r_ctrl          <= ID_EX_BUBBLE_CTRL;
            r_flush_pending <= 1'b0;
        end else if (i_stall) begin
            if (i_flush) begin
                r_flush_pending <= 1'b1;
            end
        end else begin
            r_flush_pending <= 1'b0;
            r_valid         <= w_bubble ? 1'b0 : id_ex.i_ID_valid;
            r_ctrl          <= w_bubble ? ID_EX_BUBBLE_CTRL : w_id_ctrl;
            r_pc            <= id_ex.i_ID_pc;
            r_rnum1         <= id_ex.i_ID_rnum1;
            r_rnum2         <= id_ex.i_ID_rnum2;
            r_uses_rs1      <= id_ex.i_ID_uses_rs1;
            r_uses_rs2      <= id_ex.i_ID_uses_rs2;
            r_wnum          <= id_ex.i_ID_wnum;
            r_rdata1        <= id_ex.i_ID_rdata1;
            r_rdata2        <= id_ex.i_ID_rdata2;
            r_imm           <= id_ex.i_ID_imm;
        end
    end

`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] r_lu_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_lu_stall_cnt <= '0;
            r_flush_cnt    <= '0;
        end else if (!i_stall) begin
            if (w_kill) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end else if (w_lu) begin
                r_lu_stall_cnt <= r_lu_stall_cnt + 32'd1;
            end
        end
    end

    assign o_lu_stall_cnt = r_lu_stall_cnt;
    assign o_flush_cnt    = r_flush_cnt;
`endif

    assign id_ex.o_EX_valid     = r_valid;
    assign id_ex.o_EX_pc        = r_pc;
    assign id_ex.o_EX_rnum1     = r_rnum1;
    assign id_ex.o_EX_rnum2     = r_rnum2;
    assign id_ex.o_EX_uses_rs1  = r_uses_rs1;
    assign id_ex.o_EX_uses_rs2  = r_uses_rs2;
    assign id_ex.o_EX_wnum      = r_wnum;
    assign id_ex.o_EX_wen       = r_ctrl.wen;
    assign id_ex.o_EX_mem_read  = r_ctrl.mem_read;
    assign id_ex.o_EX_mem_write = r_ctrl.mem_write;
    assign id_ex.o_EX_rdata1    = r_rdata1;
    assign id_ex.o_EX_rdata2    = r_rdata2;
    assign id_ex.o_EX_imm       = r_imm;
    assign id_ex.o_EX_alu_op    = r_ctrl.alu_op;
    assign id_ex.o_EX_alu_src   = r_ctrl.alu_src;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, with load-use hazard detection, flush and stall handling.
- Captures decoded operands and control from ID and presents them to EX.
- Its o_EX_rnum1/o_EX_rnum2 outputs are the EX read-register numbers consumed by the forwarding unit.
- Inserts one bubble on a load-use hazard, because forwarding cannot cover that case.

Parameters:
- XLEN, 32, datapath width for PC, register data and immediate.
- RESET_PC, 32'h0000_0000, reset value of o_EX_pc.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_ID_valid  in  1  ID holds a real instruction.
- i_ID_pc  in  XLEN  PC of the ID instruction.
- i_ID_rnum1, i_ID_rnum2  in  reg_t  rs1/rs2 numbers.
- i_ID_uses_rs1, i_ID_uses_rs2  in  1  the instruction actually reads rs1/rs2.
- i_ID_wnum  in  reg_t  rd number.
- i_ID_wen  in  1  register write enable.
- i_ID_mem_read, i_ID_mem_write  in  1  load/store.
- i_ID_rdata1, i_ID_rdata2  in  XLEN  register file read data.
- i_ID_imm  in  XLEN  decoded immediate.
- i_ID_alu_op  in  alu_op_t  ALU operation.
- i_ID_alu_src  in  1  ALU operand-2 select: 1 selects the immediate.
- i_flush  in  1  branch/jump taken in EX; kill the ID instruction.
- i_stall  in  1  downstream (MEM) stall; freeze this stage.
- o_EX_*  out  (same widths as the i_ID_* inputs above, valid..alu_src)  registered EX-stage copies.
- o_ID_stall  out  1  hold PC and IF/ID register this cycle.

Behaviour:
- Reset (asynchronous, i_rstn=0):
  - o_EX_valid, o_EX_wen, o_EX_mem_read, o_EX_mem_write = 0.
  - All reg_t, data and immediate outputs = 0; o_EX_alu_op = ALU_ADD; o_EX_pc = RESET_PC.
  - flush_pending = 0.
- Load-use hazard, computed combinationally:
  - lu = i_ID_valid & o_EX_valid & o_EX_mem_read & (o_EX_wnum != 0) & ((i_ID_uses_rs1 & o_EX_wnum == i_ID_rnum1) | (i_ID_uses_rs2 & o_EX_wnum == i_ID_rnum2)).
- Bubble: o_EX_valid=0, o_EX_wen=0, o_EX_mem_read=0, o_EX_mem_write=0. Other fields are don't-care; the implementation loads them from ID.
- Rising-edge priority:
  1. i_stall=1: all o_EX_* hold. If i_flush=1, set flush_pending=1.
  2. Otherwise, if (i_flush | flush_pending): load a bubble; clear flush_pending.
  3. Otherwise, if lu: load a bubble.
  4. Otherwise: load all ID fields, with o_EX_valid=i_ID_valid.
- o_ID_stall = i_stall | (lu & ~i_flush & ~flush_pending).
  - A flushed ID instruction is never stalled for.
- Latency:
  - One cycle ID->EX.
  - Load-use costs exactly one bubble. The next cycle EX holds the bubble, so lu deasserts and ID advances; the load value then reaches EX via MEM->WB forwarding (sel 01).
- Combined events:
  - lu and i_flush in the same cycle: flush wins; no stall is asserted.
  - Reset mid-stall clears flush_pending.
  - x0 destination never triggers lu.
  - A store whose rs2 depends on a load still stalls.

Optional Feature:
- Macro ID_EX_HAZARD_STATS_EN.
- When defined:
  - Adds outputs o_lu_stall_cnt (32) and o_flush_cnt (32), reset to 0.
  - o_lu_stall_cnt increments on each edge where rule 3 applies.
  - o_flush_cnt increments on each edge where rule 2 applies.
  - Both counters wrap modulo 2^32 and hold while i_stall=1.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared core package provides:
  - reg_t (logic [4:0]) and alu_op_t (enum incl. ALU_ADD).
  - The XLEN default.
  - A packed struct id_ex_ctrl_t {wen, mem_read, mem_write, alu_op, alu_src}, so the bubble is one constant ID_EX_BUBBLE_CTRL.
- One sub-module: load_use_detect (combinational lu term), reused by any future hazard logic.
- The register bank stays in id_ex_stage.

Test Plan:
- Case 1, plain advance:
  - Stimulus: ID add x3,x1,x2 (rnum1=1, rnum2=2, wnum=3, wen=1), no stall/flush.
  - Response: next cycle o_EX_valid=1, o_EX_wnum=3, o_EX_rnum1=1; o_ID_stall=0.
- Case 2, load-use:
  - Stimulus: EX holds lw x5 (mem_read=1, wnum=5); ID holds add x6,x5,x1 with uses_rs1=1.
  - Response: o_ID_stall=1 for one cycle; EX becomes a bubble (valid=0, wen=0); following cycle EX shows the add with rnum1=5.
- Case 3, false hazards:
  - Stimulus: same as case 2 but lw x0, or ID has uses_rs1=0 (lui x6).
  - Response: o_ID_stall=0 and the instruction advances.
- Case 4, flush over hazard:
  - Stimulus: lu condition true and i_flush=1 simultaneously.
  - Response: o_ID_stall=0; EX becomes a bubble.
- Case 5, flush during stall:
  - Stimulus: i_stall=1 for 3 cycles with i_flush pulsed in cycle 1.
  - Response: EX holds through all 3 cycles; the first unstalled edge loads a bubble and clears flush_pending.
- Case 6, async reset:
  - Stimulus: assert i_rstn=0 mid-sequence between clock edges.
  - Response: outputs reach reset values immediately, o_EX_pc=RESET_PC; with ID_EX_HAZARD_STATS_EN, both counters read 0 and increment as specified afterwards.
